// File: rtl/cpu_mcsr_unit_pkg.sv
// Shared machine-mode CSR definitions: addresses, mstatus fields, privilege levels,
// interrupt cause codes and mtvec modes.
package cpu_mcsr_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS        = 12'h300;
    localparam logic [11:0] CSR_MIE            = 12'h304;
    localparam logic [11:0] CSR_MTVEC          = 12'h305;
    localparam logic [11:0] CSR_MSTATUSH       = 12'h310;
    localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH       = 12'h340;
    localparam logic [11:0] CSR_MEPC           = 12'h341;
    localparam logic [11:0] CSR_MCAUSE         = 12'h342;
    localparam logic [11:0] CSR_MTVAL          = 12'h343;
    localparam logic [11:0] CSR_MIP            = 12'h344;
    localparam logic [11:0] CSR_MCYCLE         = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET       = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3   = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH        = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH      = 12'hB82;
    localparam logic [11:0] CSR_MHPMCOUNTERH3  = 12'hB83;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam logic [4:0] IRQ_MSI    = 5'd3;
    localparam logic [4:0] IRQ_MTI    = 5'd7;
    localparam logic [4:0] IRQ_MEI    = 5'd11;
    localparam logic [4:0] IRQ_LOCAL0 = 5'd16;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'b00,
        MTVEC_VECTORED = 2'b01
    } mtvec_mode_e;

    // Counter slot k -> CSR offset from mcycle: 0=mcycle, 2=minstret, 3..=mhpmcounterN.
    function automatic int ctr_csr_num(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/cpu_csr_counter.sv
// 64-bit event counter with separate lo/hi CSR write ports; a write wins over counting.
module cpu_csr_counter
    import cpu_mcsr_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    input  logic        inhibit_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (wr_lo_i)
            count_d[31:0] = wdata_i;
        else if (wr_hi_i)
            count_d[63:32] = wdata_i;
        else if (inc_i && !inhibit_i)
            count_d = count_q + 64'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpu_mcsr_unit.sv
// Machine-mode CSR unit: trap/mret state, local interrupts, vectored mtvec and
// performance counters. Sits beside writeback and steers fetch on traps.
module cpu_mcsr_unit
    import cpu_mcsr_unit_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter int              NUM_LOCAL_IRQ = 4,
    parameter int              NUM_HPM       = 2,
    parameter int              VECTORED      = 1,
    parameter int              HAS_UMODE     = 0,
    parameter logic [XLEN-1:0] RESET_VEC     = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [11:0]              raddr,
    output logic [XLEN-1:0]          rdata,
    output logic                     csr_illegal,
    input  logic [11:0]              waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic                     wenable,
    input  logic                     bubble_w,
    input  logic                     exception_w,
    input  logic [3:0]               exception_cause_w,
    input  logic [XLEN-1:0]          exception_tval_w,
    input  logic [XLEN-1:0]          pc_w,
    input  logic                     mret_w,
    input  logic [XLEN-1:0]          pc_f,
    input  logic [XLEN-1:0]          pc_d,
    input  logic [XLEN-1:0]          pc_e,
    input  logic                     bubble_d,
    input  logic                     bubble_e,
    input  logic                     msi_pending,
    input  logic                     mti_pending,
    input  logic                     mei_pending,
    input  logic [NUM_LOCAL_IRQ-1:0] local_irq,
    input  logic [NUM_HPM-1:0]       hpm_event,
    output logic                     int_req,
    input  logic                     int_ack,
    output logic [XLEN-1:0]          trap_target,
    output logic [XLEN-1:0]          mtvec,
    output logic [XLEN-1:0]          mepc,
    output logic [1:0]               priv
);

    localparam int NCTR = 2 + NUM_HPM;

    logic [1:0]      priv_q, priv_d, mpp_q, mpp_d;
    logic            st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
    logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [XLEN-1:0] minh_q, minh_d;
    logic [XLEN-1:0] mie_mask, minh_mask, mip, pend, mstatus_rd, mtvec_base, irq_pc;
    logic [4:0]      irq_code;
    logic            take_exc, take_int, wr_ok;
    logic [NCTR-1:0] ctr_inc, ctr_wr_lo, ctr_wr_hi;
    logic [63:0]     ctr_val [NCTR];

    function automatic logic csr_impl(input logic [11:0] a);
        logic hit;
        case (a)
            CSR_MSTATUS, CSR_MSTATUSH, CSR_MIE, CSR_MTVEC, CSR_MCOUNTINHIBIT,
            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP: hit = 1'b1;
            default:                                                 hit = 1'b0;
        endcase
        for (int k = 0; k < NCTR; k++)
            if (a == CSR_MCYCLE + 12'(ctr_csr_num(k)) || a == CSR_MCYCLEH + 12'(ctr_csr_num(k)))
                hit = 1'b1;
        return hit;
    endfunction

    function automatic logic mpp_legal(input logic [1:0] p);
        return (p == PRIV_M) || ((HAS_UMODE != 0) && (p == PRIV_U));
    endfunction

    always_comb begin
        mie_mask  = '0;
        minh_mask = '0;
        mip       = '0;
        mie_mask[IRQ_MSI] = 1'b1;
        mie_mask[IRQ_MTI] = 1'b1;
        mie_mask[IRQ_MEI] = 1'b1;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            mie_mask[16+i] = 1'b1;
            mip[16+i]      = local_irq[i];
        end
        for (int k = 0; k < NCTR; k++)
            minh_mask[ctr_csr_num(k)] = 1'b1;
        mip[IRQ_MSI] = msi_pending;
        mip[IRQ_MTI] = mti_pending;
        mip[IRQ_MEI] = mei_pending;
    end

    assign pend = mip & mie_q;

    // Later assignments win: locals ascending, then MTI, MSI, MEI on top.
    always_comb begin
        irq_code = '0;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++)
            if (pend[16+i]) irq_code = IRQ_LOCAL0 + 5'(i);
        if (pend[IRQ_MTI]) irq_code = IRQ_MTI;
        if (pend[IRQ_MSI]) irq_code = IRQ_MSI;
        if (pend[IRQ_MEI]) irq_code = IRQ_MEI;
    end

    assign take_exc   = exception_w;
    assign take_int   = int_ack && !exception_w;
    assign wr_ok      = wenable && csr_impl(waddr) && (waddr != CSR_MIP);
    assign irq_pc     = !bubble_e ? pc_e : (!bubble_d ? pc_d : pc_f);
    assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};

    assign int_req     = st_mie_q && (|pend) && !take_int;
    assign trap_target = (take_int && mtvec_mode_e'(mtvec_q[1:0]) == MTVEC_VECTORED)
                         ? mtvec_base + (XLEN'(irq_code) << 2) : mtvec_base;
    assign csr_illegal = !csr_impl(raddr) || (wenable && !wr_ok);
    assign mtvec       = mtvec_q;
    assign mepc        = mepc_q;
    assign priv        = priv_q;

    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MIE_BIT]                    = st_mie_q;
        mstatus_rd[MSTATUS_MPIE_BIT]                   = st_mpie_q;
        mstatus_rd[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB] = mpp_q;
        rdata = '0;
        case (raddr)
            CSR_MSTATUS:       rdata = mstatus_rd;
            CSR_MIE:           rdata = mie_q;
            CSR_MTVEC:         rdata = mtvec_q;
            CSR_MCOUNTINHIBIT: rdata = minh_q;
            CSR_MSCRATCH:      rdata = mscratch_q;
            CSR_MEPC:          rdata = mepc_q;
            CSR_MCAUSE:        rdata = mcause_q;
            CSR_MTVAL:         rdata = mtval_q;
            CSR_MIP:           rdata = mip;
            default:           rdata = '0;
        endcase
        for (int k = 0; k < NCTR; k++) begin
            if (raddr == CSR_MCYCLE  + 12'(ctr_csr_num(k))) rdata = ctr_val[k][31:0];
            if (raddr == CSR_MCYCLEH + 12'(ctr_csr_num(k))) rdata = ctr_val[k][63:32];
        end
    end

    always_comb begin
        priv_d     = priv_q;
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        mpp_d      = mpp_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        minh_d     = minh_q;
        if (wr_ok) begin
            case (waddr)
                CSR_MSTATUS: begin
                    st_mie_d  = wdata[MSTATUS_MIE_BIT];
                    st_mpie_d = wdata[MSTATUS_MPIE_BIT];
                    if (mpp_legal(wdata[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB]))
                        mpp_d = wdata[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB];
                end
                CSR_MIE:           mie_d = wdata & mie_mask;
                CSR_MTVEC:         mtvec_d = {wdata[XLEN-1:2],
                                              ((VECTORED != 0) && wdata[0]) ? MTVEC_VECTORED : MTVEC_DIRECT};
                CSR_MCOUNTINHIBIT: minh_d = wdata & minh_mask;
                CSR_MSCRATCH:      mscratch_d = wdata;
                CSR_MEPC:          mepc_d = wdata;
                CSR_MCAUSE:        mcause_d = wdata;
                CSR_MTVAL:         mtval_d = wdata;
                default: ;
            endcase
        end
        // Trap and mret are applied after the write so they override shared fields.
        if (take_exc || take_int) begin
            priv_d    = PRIV_M;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
            mpp_d     = priv_q;
            if (take_exc) begin
                mepc_d   = pc_w;
                mcause_d = {{(XLEN-4){1'b0}}, exception_cause_w};
                mtval_d  = exception_tval_w;
            end else begin
                mepc_d   = irq_pc;
                mcause_d = {1'b1, {(XLEN-6){1'b0}}, irq_code};
                mtval_d  = '0;
            end
        end else if (mret_w) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
            priv_d    = mpp_q;
            mpp_d     = (HAS_UMODE != 0) ? PRIV_U : PRIV_M;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            priv_q     <= PRIV_M;
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mpp_q      <= PRIV_M;
            mie_q      <= '0;
            mtvec_q    <= RESET_VEC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            minh_q     <= '0;
        end else begin
            priv_q     <= priv_d;
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mpp_q      <= mpp_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            minh_q     <= minh_d;
        end
    end

    always_comb begin
        ctr_inc    = '0;
        ctr_wr_lo  = '0;
        ctr_wr_hi  = '0;
        ctr_inc[0] = 1'b1;
        ctr_inc[1] = !bubble_w && !exception_w;
        for (int j = 0; j < NUM_HPM; j++)
            ctr_inc[2+j] = hpm_event[j];
        for (int k = 0; k < NCTR; k++) begin
            ctr_wr_lo[k] = wr_ok && (waddr == CSR_MCYCLE  + 12'(ctr_csr_num(k)));
            ctr_wr_hi[k] = wr_ok && (waddr == CSR_MCYCLEH + 12'(ctr_csr_num(k)));
        end
    end

    for (genvar k = 0; k < NCTR; k++) begin : g_ctr
        localparam int CSR_N = ctr_csr_num(k);
        cpu_csr_counter u_ctr (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc_i     (ctr_inc[k]),
            .inhibit_i (minh_q[CSR_N]),
            .wr_lo_i   (ctr_wr_lo[k]),
            .wr_hi_i   (ctr_wr_hi[k]),
            .wdata_i   (wdata),
            .count_o   (ctr_val[k])
        );
    end

endmodule

// File: tb/tb_cpu_mcsr_unit.sv
// Directed plus randomized bench for cpu_mcsr_unit against a behavioural CSR model.
module tb_cpu_mcsr_unit;

    localparam int NL = 4;
    localparam int NH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] raddr, waddr;
    logic [31:0] rdata, wdata;
    logic        csr_illegal, wenable, bubble_w, exception_w, mret_w;
    logic [3:0]  exception_cause_w;
    logic [31:0] exception_tval_w, pc_w, pc_f, pc_d, pc_e;
    logic        bubble_d, bubble_e, msi_pending, mti_pending, mei_pending;
    logic [NL-1:0] local_irq;
    logic [NH-1:0] hpm_event;
    logic        int_req, int_ack;
    logic [31:0] trap_target, mtvec, mepc;
    logic [1:0]  priv;

    always #5 clk = ~clk;

    cpu_mcsr_unit #(.XLEN(32), .NUM_LOCAL_IRQ(NL), .NUM_HPM(NH), .VECTORED(1),
                    .HAS_UMODE(0), .RESET_VEC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .csr_illegal(csr_illegal),
        .waddr(waddr), .wdata(wdata), .wenable(wenable), .bubble_w(bubble_w),
        .exception_w(exception_w), .exception_cause_w(exception_cause_w),
        .exception_tval_w(exception_tval_w), .pc_w(pc_w), .mret_w(mret_w),
        .pc_f(pc_f), .pc_d(pc_d), .pc_e(pc_e), .bubble_d(bubble_d), .bubble_e(bubble_e),
        .msi_pending(msi_pending), .mti_pending(mti_pending), .mei_pending(mei_pending),
        .local_irq(local_irq), .hpm_event(hpm_event), .int_req(int_req), .int_ack(int_ack),
        .trap_target(trap_target), .mtvec(mtvec), .mepc(mepc), .priv(priv)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_mie, m_mpie;
    bit [1:0]    m_mpp, m_priv;
    bit [31:0]   m_mie_r, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_minh;
    bit [63:0]   m_cnt [4];
    int          cnt_num [4] = '{0, 2, 3, 4};
    logic [11:0] addrs [22] = '{12'h300, 12'h310, 12'h304, 12'h305, 12'h320, 12'h340,
                                12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02,
                                12'hB03, 12'hB04, 12'hB80, 12'hB82, 12'hB83, 12'hB84,
                                12'h7C0, 12'h301, 12'hB01, 12'hB05};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] model_mip();
        return (32'(msi_pending) << 3) | (32'(mti_pending) << 7) |
               (32'(mei_pending) << 11) | (32'(local_irq) << 16);
    endfunction

    function automatic int model_code();
        bit [31:0] p = model_mip() & m_mie_r;
        if (p[11]) return 11;
        if (p[3])  return 3;
        if (p[7])  return 7;
        for (int i = NL - 1; i >= 0; i--)
            if (p[16+i]) return 16 + i;
        return 0;
    endfunction

    function automatic int ctr_slot(input logic [11:0] a);
        for (int k = 0; k < 4; k++)
            if (a == 12'hB00 + 12'(cnt_num[k]) || a == 12'hB80 + 12'(cnt_num[k])) return k;
        return -1;
    endfunction

    function automatic bit model_legal(input logic [11:0] a);
        if (ctr_slot(a) >= 0) return 1'b1;
        return (a == 12'h300) || (a == 12'h310) || (a == 12'h304) || (a == 12'h305) ||
               (a == 12'h320) || (a >= 12'h340 && a <= 12'h344);
    endfunction

    function automatic bit [31:0] model_read(input logic [11:0] a);
        int k = ctr_slot(a);
        if (k >= 0) return a[7] ? m_cnt[k][63:32] : m_cnt[k][31:0];
        case (a)
            12'h300: return {19'b0, m_mpp, 3'b0, m_mpie, 3'b0, m_mie, 3'b0};
            12'h304: return m_mie_r;
            12'h305: return m_mtvec;
            12'h320: return m_minh;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return model_mip();
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_int_req();
        return m_mie && ((model_mip() & m_mie_r) != 0) && !(int_ack && !exception_w);
    endfunction

    function automatic bit [31:0] model_target();
        bit [31:0] base = m_mtvec & 32'hFFFF_FFFC;
        if (int_ack && !exception_w && m_mtvec[0]) return base + 32'(4 * model_code());
        return base;
    endfunction

    task automatic check_outputs();
        check("rdata", rdata, model_read(raddr));
        check("csr_illegal", csr_illegal,
              !model_legal(raddr) || (wenable && (!model_legal(waddr) || waddr == 12'h344)));
        check("int_req", int_req, model_int_req());
        check("trap_target", trap_target, model_target());
        check("mtvec", mtvec, m_mtvec);
        check("mepc", mepc, m_mepc);
        check("priv", priv, m_priv);
    endtask

    task automatic model_update();
        bit        o_mie = m_mie, o_mpie = m_mpie;
        bit [1:0]  o_mpp = m_mpp, o_priv = m_priv;
        int        code = model_code();
        bit [31:0] ipc = !bubble_e ? pc_e : (!bubble_d ? pc_d : pc_f);
        bit        wr = wenable && model_legal(waddr) && waddr != 12'h344;
        bit        take_i = int_ack && !exception_w;
        for (int k = 0; k < 4; k++) begin
            bit inc = (k == 0) ? 1'b1 : (k == 1) ? (!bubble_w && !exception_w) : hpm_event[k-2];
            if (wr && waddr == 12'hB00 + 12'(cnt_num[k]))      m_cnt[k][31:0]  = wdata;
            else if (wr && waddr == 12'hB80 + 12'(cnt_num[k])) m_cnt[k][63:32] = wdata;
            else if (inc && !m_minh[cnt_num[k]])               m_cnt[k] = m_cnt[k] + 1;
        end
        if (wr) begin
            case (waddr)
                12'h300: begin
                    m_mie  = wdata[3];
                    m_mpie = wdata[7];
                    if (wdata[12:11] == 2'd3) m_mpp = 2'd3;
                end
                12'h304: m_mie_r    = wdata & 32'h000F_0888;
                12'h305: m_mtvec    = wdata & 32'hFFFF_FFFD;
                12'h320: m_minh     = wdata & 32'h0000_001D;
                12'h340: m_mscratch = wdata;
                12'h341: m_mepc     = wdata;
                12'h342: m_mcause   = wdata;
                12'h343: m_mtval    = wdata;
                default: ;
            endcase
        end
        if (exception_w || take_i) begin
            m_priv = 2'd3;
            m_mpie = o_mie;
            m_mie  = 1'b0;
            m_mpp  = o_priv;
            if (exception_w) begin
                m_mepc   = pc_w;
                m_mcause = 32'(exception_cause_w);
                m_mtval  = exception_tval_w;
            end else begin
                m_mepc   = ipc;
                m_mcause = 32'h8000_0000 | 32'(code);
                m_mtval  = 32'h0;
            end
        end else if (mret_w) begin
            m_mie  = o_mpie;
            m_mpie = 1'b1;
            m_priv = o_mpp;
            m_mpp  = 2'd3;
        end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        waddr = a; wdata = d; wenable = 1'b1;
        tick();
        wenable = 1'b0;
    endtask

    task automatic chk_rd(input logic [11:0] a, input string tag, input logic [31:0] exp);
        raddr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        bit [63:0] saved;
        rst_n = 1'b0; raddr = 12'h300; waddr = 12'h0; wdata = 32'h0; wenable = 1'b0;
        bubble_w = 1'b1; exception_w = 1'b0; exception_cause_w = 4'h0; exception_tval_w = 32'h0;
        pc_w = 32'h0; mret_w = 1'b0; pc_f = 32'h0; pc_d = 32'h0; pc_e = 32'h0;
        bubble_d = 1'b1; bubble_e = 1'b1; msi_pending = 1'b0; mti_pending = 1'b0;
        mei_pending = 1'b0; local_irq = '0; hpm_event = '0; int_ack = 1'b0;
        m_mie = 0; m_mpie = 0; m_mpp = 2'd3; m_priv = 2'd3; m_mie_r = 0; m_mtvec = 0;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_minh = 0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 64'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk_rd(12'h300, "mstatus_reset", 32'h0000_1800);
        chk_rd(12'h305, "mtvec_reset", 32'h0);
        chk_rd(12'hB00, "mcycle_reset", 32'h0);
        check("int_req_reset", int_req, 1'b0);
        check("priv_reset", priv, 2'd3);
        chk_rd(12'h7C0, "unimpl_rdata", 32'h0);
        check("unimpl_illegal", csr_illegal, 1'b1);
        tick();
        chk_rd(12'hB00, "mcycle_counting", 32'h1);

        // Vectored MTI interrupt
        wr(12'h305, 32'h0000_1001);
        wr(12'h304, 32'h0000_0080);
        wr(12'h300, 32'h0000_1808);
        mti_pending = 1'b1;
        #1 check("int_req_mti", int_req, 1'b1);
        pc_e = 32'h40; bubble_e = 1'b0; int_ack = 1'b1;
        #1 check("trap_target_vec", trap_target, 32'h0000_101C);
        check("int_req_ack_forced", int_req, 1'b0);
        tick();
        int_ack = 1'b0;
        chk_rd(12'h341, "mepc_irq", 32'h40);
        chk_rd(12'h342, "mcause_mti", 32'h8000_0007);
        chk_rd(12'h300, "mstatus_after_irq", 32'h0000_1880);
        check("int_req_after_irq", int_req, 1'b0);

        // Priority: MEI over local, then local 0
        mti_pending = 1'b0;
        wr(12'h304, 32'h0001_0888);
        wr(12'h300, 32'h0000_1808);
        local_irq = 4'b0001; mei_pending = 1'b1; int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_rd(12'h342, "mcause_mei", 32'h8000_000B);
        mei_pending = 1'b0;
        wr(12'h300, 32'h0000_1808);
        int_ack = 1'b1;
        #1 check("trap_target_local", trap_target, 32'h0000_1040);
        tick();
        int_ack = 1'b0;
        chk_rd(12'h342, "mcause_local0", 32'h8000_0010);

        // Exception beats same-cycle int_ack and mepc write
        wr(12'h300, 32'h0000_1808);
        exception_w = 1'b1; exception_cause_w = 4'd2; exception_tval_w = 32'hDEAD_BEEF;
        pc_w = 32'h200; int_ack = 1'b1; waddr = 12'h341; wdata = 32'h5; wenable = 1'b1;
        #1 check("int_req_exc_cycle", int_req, 1'b1);
        check("trap_target_exc", trap_target, 32'h0000_1000);
        tick();
        exception_w = 1'b0; int_ack = 1'b0; wenable = 1'b0;
        chk_rd(12'h341, "mepc_exc", 32'h200);
        chk_rd(12'h342, "mcause_exc", 32'h2);
        chk_rd(12'h343, "mtval_exc", 32'hDEAD_BEEF);

        // mret restores MIE from MPIE
        mret_w = 1'b1;
        tick();
        mret_w = 1'b0;
        chk_rd(12'h300, "mstatus_mret", 32'h0000_1888);
        check("priv_mret", priv, 2'd3);

        // minstret inhibit, then mcycle 64-bit wrap
        wr(12'h320, 32'h4);
        saved = m_cnt[1];
        bubble_w = 1'b0;
        repeat (10) tick();
        chk_rd(12'hB02, "minstret_inhibit", saved[31:0]);
        bubble_w = 1'b1;
        wr(12'h320, 32'h0);
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        chk_rd(12'hB00, "mcycle_lo_written", 32'hFFFF_FFFF);
        chk_rd(12'hB80, "mcycle_hi_written", 32'hFFFF_FFFF);
        tick();
        chk_rd(12'hB00, "mcycle_lo_wrap", 32'h0);
        chk_rd(12'hB80, "mcycle_hi_wrap", 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            raddr = addrs[$urandom_range(0, 21)];
            wenable = ($urandom_range(0, 2) == 0);
            waddr = addrs[$urandom_range(0, 21)];
            wdata = $urandom;
            bubble_w = $urandom_range(0, 1) == 1;
            bubble_d = $urandom_range(0, 1) == 1;
            bubble_e = $urandom_range(0, 1) == 1;
            exception_w = ($urandom_range(0, 9) == 0);
            exception_cause_w = 4'($urandom);
            exception_tval_w = $urandom;
            pc_w = $urandom; pc_f = $urandom; pc_d = $urandom; pc_e = $urandom;
            mret_w = ($urandom_range(0, 9) == 0);
            int_ack = ($urandom_range(0, 7) == 0);
            msi_pending = ($urandom_range(0, 3) == 0);
            mti_pending = ($urandom_range(0, 3) == 0);
            mei_pending = ($urandom_range(0, 3) == 0);
            local_irq = NL'($urandom);
            hpm_event = NH'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
